// File: rtl/music_box_pkg.sv
// Shared types and constants for the music box play states.
// Tone-word layout helpers and the play-song FSM encoding.
package music_box_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } play_state_t;

  // Note word is {end_flag, tone, duration}, duration in the LSBs.
  localparam int DUR_LSB   = 0;
  localparam int REST_TONE = 0;

  function automatic int tone_lsb(input int dur_w);
    return DUR_LSB + dur_w;
  endfunction

  function automatic int end_bit(input int tone_w, input int dur_w);
    return tone_lsb(dur_w) + tone_w;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider with hold (enable) and restart (clear).
// tick pulses on the last enabled cycle of each TICK_DIV period.
module tick_prescaler #(
  parameter  int TICK_DIV = 500000,
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic             tick,
  output logic [CNT_W-1:0] count
);

  assign tick = enable && (count == CNT_W'(TICK_DIV - 1));

  // Count while enabled, wrap on tick, restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/music_box_state_play_song.sv
// Song player state: walks a note ROM and drives the tone synthesiser.
// Supports song select, pause, looping and a rest gap between notes.
module music_box_state_play_song
  import music_box_pkg::*;
#(
  parameter  int STATE_ID    = 1,
  parameter  int NUM_SONGS   = 4,
  parameter  int NOTE_ADDR_W = 8,
  parameter  int TONE_W      = 6,
  parameter  int DUR_W       = 8,
  parameter  int TICK_DIV    = 500000,
  parameter  int GAP_TICKS   = 2,
  localparam int SONG_W      = $clog2(NUM_SONGS),
  localparam int WORD_W      = 1 + TONE_W + DUR_W
) (
  input  logic                          clock_50Mhz,
  input  logic                          reset,
  input  logic [4:0]                    currentState,
  input  logic [SONG_W-1:0]             songSelect,
  input  logic                          loopEnable,
  input  logic                          pause,
  output logic [SONG_W+NOTE_ADDR_W-1:0] noteAddr,
  input  logic [WORD_W-1:0]             noteData,
  output logic [TONE_W-1:0]             toneIndex,
  output logic                          toneValid,
  output logic [NOTE_ADDR_W-1:0]        noteIdx,
  output logic [31:0]                   debugString,
  output logic                          stateComplete
);

  localparam int TONE_LSB = tone_lsb(DUR_W);
  localparam int END_BIT  = end_bit(TONE_W, DUR_W);
  localparam int GAP_W    = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  play_state_t          state_q;
  logic [SONG_W-1:0]    song_q;
  logic [NOTE_ADDR_W-1:0] idx_q;
  logic [TONE_W-1:0]    tone_q;
  logic                 tone_on_q;
  logic                 done_q;
  logic [DUR_W-1:0]     dur_q;
  logic [GAP_W-1:0]     gap_q;

  logic                 w_end;
  logic [TONE_W-1:0]    w_tone;
  logic [DUR_W-1:0]     w_dur;

  logic                 active;
  logic                 timed;
  logic                 run;
  logic                 tick;
  logic [CNT_W-1:0]     tick_cnt;
  logic                 last_idx;
  logic                 seq_adv;
  logic                 seq_end;

  assign w_end  = noteData[END_BIT];
  assign w_tone = noteData[TONE_LSB +: TONE_W];
  assign w_dur  = noteData[DUR_LSB +: DUR_W];

  assign active   = (currentState == 5'(STATE_ID));
  assign timed    = (state_q == S_PLAY) || (state_q == S_GAP);
  assign run      = active && timed && !pause;
  assign last_idx = &idx_q;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clock_50Mhz),
    .reset  (reset),
    .clear  (!timed),
    .enable (run),
    .tick   (tick),
    .count  (tick_cnt)
  );

  // Decide when the current note is finished and whether the song ends.
  always_comb begin
    seq_adv = 1'b0;
    seq_end = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        seq_end = w_end;
        seq_adv = !w_end && (w_dur == '0);
      end
      S_PLAY: begin
        seq_adv = (GAP_TICKS == 0) && tick &&
                  (dur_q == DUR_W'(1));
      end
      S_GAP: begin
        seq_adv = tick && (gap_q == GAP_W'(1));
      end
      default: begin
        seq_adv = 1'b0;
      end
    endcase
    if (seq_adv && last_idx) begin
      seq_end = 1'b1;
    end
  end

  // Player FSM: fetch, decode, play, gap, then advance, loop or finish.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state_q   <= S_IDLE;
      song_q    <= '0;
      idx_q     <= '0;
      tone_q    <= '0;
      tone_on_q <= 1'b0;
      done_q    <= 1'b0;
      dur_q     <= '0;
      gap_q     <= '0;
    end else if (state_q != S_IDLE && !active) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      tone_q    <= TONE_W'(REST_TONE);
      tone_on_q <= 1'b0;
      done_q    <= 1'b0;
      dur_q     <= '0;
      gap_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (active) begin
            song_q  <= songSelect;
            idx_q   <= '0;
            done_q  <= 1'b0;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (!w_end && w_dur != '0) begin
            tone_q    <= w_tone;
            tone_on_q <= (w_tone != TONE_W'(REST_TONE));
            dur_q     <= w_dur;
            state_q   <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (tick) begin
            if (dur_q == DUR_W'(1)) begin
              tone_on_q <= 1'b0;
              dur_q     <= '0;
              if (GAP_TICKS != 0) begin
                gap_q   <= GAP_W'(GAP_TICKS);
                state_q <= S_GAP;
              end
            end else begin
              dur_q <= dur_q - DUR_W'(1);
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        S_DONE: begin
          done_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      if (seq_end) begin
        if (loopEnable) begin
          song_q  <= songSelect;
          idx_q   <= '0;
          state_q <= S_FETCH;
        end else begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
      end else if (seq_adv) begin
        idx_q   <= idx_q + NOTE_ADDR_W'(1);
        state_q <= S_FETCH;
      end
    end
  end

  assign noteAddr      = {song_q, idx_q};
  assign toneIndex     = tone_q;
  assign toneValid     = tone_on_q && !pause;
  assign noteIdx       = idx_q;
  assign stateComplete = done_q;

  // Debug word: state, note index, prescaler count.
  always_comb begin
    debugString = {3'b000, state_q, 2'b00,
                   8'(idx_q), 16'(tick_cnt)};
  end

endmodule

// File: tb/tb_music_box_state_play_song.sv
// Directed bench for the song player state with a behavioural ROM.
// TICK_DIV=4, GAP_TICKS=1 so every note and gap is a few cycles.
module tb_music_box_state_play_song;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  cs = 5'd0;
  logic [1:0]  ss = 2'd0;
  logic        loop_en = 1'b0;
  logic        pause = 1'b0;
  logic [9:0]  note_addr;
  logic [14:0] note_data;
  logic [5:0]  tone_idx;
  logic        tone_valid;
  logic [7:0]  note_idx;
  logic [31:0] dbg;
  logic        done;

  logic [14:0] rom [0:1023];

  logic        tv [0:63];
  logic [5:0]  ti [0:63];
  logic        sc [0:63];
  logic [7:0]  ni [0:63];
  logic [9:0]  na [0:63];
  logic [31:0] ds [0:63];

  int checks = 0;
  int failures = 0;
  int done_at;
  int tvc;

  always #5 clk = ~clk;

  always @(posedge clk) note_data <= rom[note_addr];

  music_box_state_play_song #(
    .STATE_ID    (1),
    .NUM_SONGS   (4),
    .NOTE_ADDR_W (8),
    .TONE_W      (6),
    .DUR_W       (8),
    .TICK_DIV    (4),
    .GAP_TICKS   (1)
  ) dut (
    .clock_50Mhz   (clk),
    .reset         (reset),
    .currentState  (cs),
    .songSelect    (ss),
    .loopEnable    (loop_en),
    .pause         (pause),
    .noteAddr      (note_addr),
    .noteData      (note_data),
    .toneIndex     (tone_idx),
    .toneValid     (tone_valid),
    .noteIdx       (note_idx),
    .debugString   (dbg),
    .stateComplete (done)
  );

  function automatic logic [14:0] w(input bit e, input int t, input int d);
    return {e, 6'(t), 8'(d)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic rec(input int n, input int pon, input int poff);
    for (int i = 0; i < n; i++) begin
      pause = (i >= pon) && (i < poff);
      @(negedge clk);
      tv[i] = tone_valid;
      ti[i] = tone_idx;
      sc[i] = done;
      ni[i] = note_idx;
      na[i] = note_addr;
      ds[i] = dbg;
      @(posedge clk);
      #1;
    end
    pause = 1'b0;
  endtask

  function automatic int cnt(input int lo, input int hi, input int tone);
    int c = 0;
    for (int i = lo; i <= hi; i++)
      if (tv[i] && ti[i] == 6'(tone)) c++;
    return c;
  endfunction

  function automatic int first_on(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      if (tv[i]) return i;
    return -1;
  endfunction

  function automatic int any_done(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++)
      if (sc[i]) c++;
    return c;
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = w(1, 0, 0);
    rom[0]   = w(0, 5, 3);
    rom[1]   = w(0, 9, 1);
    rom[2]   = w(1, 0, 0);
    rom[512] = w(0, 0, 2);
    rom[513] = w(0, 7, 0);
    rom[514] = w(1, 0, 0);
    for (int i = 0; i < 256; i++) rom[768 + i] = w(0, 1, 1);

    // reset state
    next();
    next();
    @(negedge clk);
    chk("rst_valid", 32'(tone_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(note_addr), 0);
    chk("rst_tone", 32'(tone_idx), 0);
    chk("rst_idx", 32'(note_idx), 0);
    chk("rst_dbg", dbg, 0);
    next();
    reset = 1'b0;
    next();

    // song 0, single pass
    cs = 5'd1;
    next();
    rec(40, 0, 0);
    chk("t1_addr0", 32'(na[0]), 0);
    chk("t1_st_fetch", 32'(ds[0][28:26]), 1);
    chk("t1_st_load", 32'(ds[1][28:26]), 2);
    chk("t1_first_on", 32'(first_on(0, 39)), 2);
    chk("t1_tone5_len", 32'(cnt(0, 17, 5)), 12);
    chk("t1_last5", 32'(tv[13]), 1);
    chk("t1_gap", 32'(tv[14]), 0);
    chk("t1_idx1", 32'(ni[18]), 1);
    chk("t1_addr1", 32'(na[18]), 1);
    chk("t1_tone9_len", 32'(cnt(18, 29, 9)), 4);
    chk("t1_tone9_on", 32'(first_on(18, 39)), 20);
    chk("t1_done_pre", 32'(sc[29]), 0);
    chk("t1_done", 32'(sc[30]), 1);
    chk("t1_done_hold", 32'(sc[39]), 1);
    chk("t1_st_done", 32'(ds[30][28:26]), 5);
    cs = 5'd0;
    @(negedge clk);
    chk("t1_done_last", 32'(done), 1);
    next();
    @(negedge clk);
    chk("t1_done_clr", 32'(done), 0);
    chk("t1_st_idle", 32'(dbg[28:26]), 0);
    next();

    // song 0 looping
    loop_en = 1'b1;
    cs = 5'd1;
    next();
    rec(60, 0, 0);
    chk("t2_idx_end", 32'(ni[29]), 2);
    chk("t2_idx_wrap", 32'(ni[30]), 0);
    chk("t2_replay_on", 32'(first_on(30, 59)), 32);
    chk("t2_replay_tone", 32'(ti[32]), 5);
    chk("t2_replay_len", 32'(cnt(30, 59, 5)), 12);
    chk("t2_no_done", 32'(any_done(0, 59)), 0);
    cs = 5'd0;
    loop_en = 1'b0;
    next();
    next();

    // pause for 7 cycles in the middle of tone 5
    cs = 5'd1;
    next();
    rec(26, 5, 12);
    chk("t3_pre", 32'(tv[4]), 1);
    chk("t3_p_start", 32'(tv[5]), 0);
    chk("t3_p_end", 32'(tv[11]), 0);
    chk("t3_resume", 32'(tv[12]), 1);
    chk("t3_hold_tone", 32'(ti[8]), 5);
    chk("t3_hold_cnt", 32'(ds[11][15:0]), 3);
    chk("t3_tail", 32'(tv[20]), 1);
    chk("t3_gap", 32'(tv[21]), 0);
    chk("t3_len", 32'(cnt(0, 25, 5)), 12);
    cs = 5'd0;
    next();
    next();

    // abort while tone 9 plays, then restart
    cs = 5'd1;
    next();
    rec(22, 0, 0);
    chk("t4_pre_tone", 32'(ti[21]), 9);
    chk("t4_pre_idx", 32'(ni[21]), 1);
    cs = 5'd0;
    next();
    @(negedge clk);
    chk("t4_ab_valid", 32'(tone_valid), 0);
    chk("t4_ab_state", 32'(dbg[28:26]), 0);
    chk("t4_ab_idx", 32'(note_idx), 0);
    next();
    cs = 5'd1;
    next();
    rec(14, 0, 0);
    chk("t4_re_idx", 32'(ni[0]), 0);
    chk("t4_re_addr", 32'(na[0]), 0);
    chk("t4_re_on", 32'(first_on(0, 13)), 2);
    chk("t4_re_tone", 32'(ti[2]), 5);
    cs = 5'd0;
    next();
    next();

    // song 2: rest note, zero-duration skip, end
    ss = 2'd2;
    cs = 5'd1;
    next();
    rec(20, 0, 0);
    chk("t5_addr", 32'(na[0]), 512);
    chk("t5_silent", 32'(first_on(0, 19)), -1);
    chk("t5_rest_tone", 32'(ti[5]), 0);
    chk("t5_st_play", 32'(ds[5][28:26]), 3);
    chk("t5_st_play_end", 32'(ds[9][28:26]), 3);
    chk("t5_st_gap", 32'(ds[10][28:26]), 4);
    chk("t5_tickcnt", 32'(ds[3][15:0]), 1);
    chk("t5_idx1", 32'(ni[15]), 1);
    chk("t5_skip", 32'(ni[16]), 2);
    chk("t5_done_pre", 32'(sc[17]), 0);
    chk("t5_done", 32'(sc[18]), 1);
    cs = 5'd0;
    ss = 2'd0;
    next();
    next();

    // reset in the middle of a note
    cs = 5'd1;
    next();
    rec(6, 0, 0);
    chk("t6_pre", 32'(tv[5]), 1);
    reset = 1'b1;
    next();
    @(negedge clk);
    chk("t6_valid", 32'(tone_valid), 0);
    chk("t6_tone", 32'(tone_idx), 0);
    chk("t6_addr", 32'(note_addr), 0);
    chk("t6_idx", 32'(note_idx), 0);
    chk("t6_dbg", dbg, 0);
    chk("t6_done", 32'(done), 0);
    cs = 5'd0;
    next();
    reset = 1'b0;
    next();

    // song 3: 256 notes without an end word
    ss = 2'd3;
    cs = 5'd1;
    next();
    done_at = -1;
    tvc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        done_at = k;
        break;
      end
      if (tone_valid) tvc++;
      @(posedge clk);
      #1;
    end
    chk("t7_done_at", 32'(done_at), 2560);
    chk("t7_sound", 32'(tvc), 1024);
    chk("t7_last_idx", 32'(note_idx), 255);
    cs = 5'd0;
    next();
    next();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
